// File: rtl/mem_bus_responder.sv
// Byte-serial memory bus responder: byte RAM with one-cycle read latency plus an IO
// window at 0x30000 (UART TX FIFO, halt flag). Define IO_RX_EN to add the RX byte latch.
module mem_bus_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] bus_addr,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        halt_out,
  output logic        tx_overflow
);

  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [17:0] IO_TX  = 18'h30000;
  localparam logic [17:0] IO_CTL = 18'h30004;

  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] fifo_mem [TX_FIFO_DEPTH];

  logic [7:0]  rdata_q, rdata_d;
  logic        io_full_q, io_full_d;
  logic        halt_q, halt_d;
  logic        ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       is_io, io_rd_tx, io_wr_tx, io_wr_ctl, io_rd_ctl;
  logic       fifo_empty, fifo_full, push, pop;
  logic [7:0] rx_rdata;

  assign is_io     = (bus_addr[17:16] == 2'b11);
  assign io_wr_tx  = bus_wr  && is_io && (bus_addr[17:0] == IO_TX);
  assign io_wr_ctl = bus_wr  && is_io && (bus_addr[17:0] == IO_CTL);
  assign io_rd_tx  = !bus_wr && is_io && (bus_addr[17:0] == IO_TX);
  assign io_rd_ctl = !bus_wr && is_io && (bus_addr[17:0] == IO_CTL);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(TX_FIFO_DEPTH));
  assign pop        = !fifo_empty && uart_tx_ready;
  // A simultaneous pop frees the slot this push needs, so full-and-popping still accepts.
  assign push       = io_wr_tx && (!fifo_full || pop);

`ifdef IO_RX_EN
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  always_comb begin
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (io_rd_tx) rx_full_d = 1'b0;
    // A fresh strobe wins over the read-clear; the reader still sees the old latch value.
    if (uart_rx_valid) begin
      rx_full_d = 1'b1;
      rx_byte_d = uart_rx_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign rx_rdata = rx_full_q ? rx_byte_q : 8'h00;

  logic unused_bits;
  assign unused_bits = ^bus_addr[31:18];
`else
  assign rx_rdata = 8'h00;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[31:18], uart_rx_valid, uart_rx_data, io_rd_tx};
`endif

  always_comb begin
    rdata_d  = rdata_q;
    halt_d   = halt_q || io_wr_ctl;
    ovf_d    = ovf_q || (io_wr_tx && !push);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    io_full_d = (count_d >= CW'(TX_FIFO_DEPTH - FULL_MARGIN));
    if (!bus_wr) begin
      if (!is_io)          rdata_d = ram[bus_addr[ADDR_WIDTH-1:0]];
      else if (io_rd_tx)   rdata_d = rx_rdata;
      else if (io_rd_ctl)  rdata_d = {7'b0, fifo_empty};
      else                 rdata_d = 8'h00;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdata_q   <= 8'h00;
      io_full_q <= 1'b0;
      halt_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rdata_q   <= rdata_d;
      io_full_q <= io_full_d;
      halt_q    <= halt_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage arrays are not reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk_in) begin
    if (bus_wr && !is_io) ram[bus_addr[ADDR_WIDTH-1:0]] <= bus_wdata;
    if (push)             fifo_mem[wr_ptr_q] <= bus_wdata;
  end

  assign bus_rdata      = rdata_q;
  assign io_buffer_full = io_full_q;
  assign uart_tx_valid  = !fifo_empty;
  assign uart_tx_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
  assign halt_out       = halt_q;
  assign tx_overflow    = ovf_q;

endmodule
